// File: rtl/mem_stride_addr_gen_pkg.sv
// Shared types and default widths for the strided memory address generator.
package mem_addr_gen_pkg;

    localparam int ADDR_W_DEF     = 6;
    localparam int COUNT_W_DEF    = 7;
    localparam int STRIDE_W_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]   addr;
        logic [COUNT_W_DEF-1:0]  count;
        logic [STRIDE_W_DEF-1:0] stride;
        logic                    wen;
    } desc_t;

    function automatic int desc_width(input int addr_w, input int count_w, input int stride_w);
        return addr_w + count_w + stride_w + 1;
    endfunction

endpackage

// File: rtl/mem_stride_addr_gen_if.sv
// Descriptor handshake and memory-side access bus of the address generator.
interface mem_stride_addr_gen_if
    import mem_addr_gen_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [COUNT_W-1:0]  cmd_count;
    logic [STRIDE_W-1:0] cmd_stride;
    logic                cmd_wen;

    logic                mem_ready;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic                mem_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_count, cmd_stride, cmd_wen, mem_ready,
        input  cmd_ready, mem_valid, mem_addr, mem_wen, mem_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_count, cmd_stride, cmd_wen, mem_ready,
        output cmd_ready, mem_valid, mem_addr, mem_wen, mem_last
    );

endinterface

// File: rtl/mem_stride_addr_gen_cmd_fifo.sv
// Small synchronous FIFO with full/empty flags; pointers carry one extra wrap bit.
module cmd_fifo
    import mem_addr_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mem_stride_addr_gen.sv
// Self-sequencing strided address generator feeding one CADA memory bank port.
// Define ADDR_GEN_WRAP_ERR_EN to add the sticky wrap_err output.
module mem_stride_addr_gen
    import mem_addr_gen_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int COUNT_W    = COUNT_W_DEF,
    parameter int STRIDE_W   = STRIDE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_stride_addr_gen_if.slave  bus,
    output logic                  burst_done,
    output logic                  busy
`ifdef ADDR_GEN_WRAP_ERR_EN
    ,
    output logic                  wrap_err
`endif
);

    localparam int DESC_W = desc_width(ADDR_W, COUNT_W, STRIDE_W);

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [DESC_W-1:0] head_data;

    logic [ADDR_W-1:0]   head_addr;
    logic [COUNT_W-1:0]  head_count;
    logic [STRIDE_W-1:0] head_stride;
    logic                head_wen;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [COUNT_W-1:0]  remaining_q, remaining_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                wen_q, wen_d;
    logic                burst_done_q, burst_done_d;
    logic                ready_en_q, ready_en_d;

    logic run, accept, finishing;

`ifdef ADDR_GEN_WRAP_ERR_EN
    logic              wrap_err_q, wrap_err_d;
    logic [ADDR_W:0]   wrap_sum;
`endif

    assign {head_addr, head_count, head_stride, head_wen} = head_data;

    cmd_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({bus.cmd_addr, bus.cmd_count, bus.cmd_stride, bus.cmd_wen}),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign run       = (state_q == RUN);
    assign accept    = run && bus.mem_ready;
    assign finishing = accept && (remaining_q == COUNT_W'(1));
    // A new head loads whenever the engine is idle or retiring its last access, so bursts chain without a bubble.
    assign pop       = (!run || finishing) && !fifo_empty;
    assign push      = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        stride_d     = stride_q;
        wen_d        = wen_q;
        burst_done_d = 1'b0;
        ready_en_d   = 1'b1;

        if (accept) begin
            cur_addr_d  = cur_addr_q + ADDR_W'(stride_q);
            remaining_d = remaining_q - COUNT_W'(1);
        end
        if (finishing) begin
            state_d      = IDLE;
            burst_done_d = 1'b1;
        end
        if (pop) begin
            if (head_count == '0) begin
                state_d      = IDLE;
                burst_done_d = 1'b1;
            end else begin
                state_d     = RUN;
                cur_addr_d  = head_addr;
                remaining_d = head_count;
                stride_d    = head_stride;
                wen_d       = head_wen;
            end
        end
    end

`ifdef ADDR_GEN_WRAP_ERR_EN
    always_comb begin
        wrap_sum   = {1'b0, cur_addr_q} + (ADDR_W+1)'(stride_q);
        wrap_err_d = wrap_err_q;
        if (accept && (remaining_q > COUNT_W'(1)) && wrap_sum[ADDR_W]) begin
            wrap_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err_q <= 1'b0;
        end else begin
            wrap_err_q <= wrap_err_d;
        end
    end

    assign wrap_err = wrap_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            stride_q     <= '0;
            wen_q        <= 1'b0;
            burst_done_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            stride_q     <= stride_d;
            wen_q        <= wen_d;
            burst_done_q <= burst_done_d;
            ready_en_q   <= ready_en_d;
        end
    end

    // ready_en_q keeps cmd_ready low through reset and until the first edge afterwards.
    assign bus.cmd_ready = ready_en_q && !fifo_full;
    assign bus.mem_valid = run;
    assign bus.mem_addr  = run ? cur_addr_q : '0;
    assign bus.mem_wen   = run && wen_q;
    assign bus.mem_last  = run && (remaining_q == COUNT_W'(1));
    assign burst_done    = burst_done_q;
    assign busy          = run || !fifo_empty;

endmodule

// File: tb/tb_mem_stride_addr_gen.sv
// Self-checking bench: directed table, hand-written corner sequences and a randomized scoreboard run.
module tb_mem_stride_addr_gen;
    import mem_addr_gen_pkg::*;

    typedef struct packed {
        desc_t           d;
        logic [3:0][5:0] exp;
    } vec_t;

    typedef struct packed {
        logic [5:0] addr;
        logic       wen;
        logic       last;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n;
    logic burst_done;
    logic busy;
`ifdef ADDR_GEN_WRAP_ERR_EN
    logic wrap_err;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mem_stride_addr_gen_if bus ();

    mem_stride_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .burst_done (burst_done),
        .busy       (busy)
`ifdef ADDR_GEN_WRAP_ERR_EN
        ,
        .wrap_err   (wrap_err)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input desc_t d, input logic valid);
        bus.cmd_valid  = valid;
        bus.cmd_addr   = d.addr;
        bus.cmd_count  = d.count;
        bus.cmd_stride = d.stride;
        bus.cmd_wen    = d.wen;
    endtask

    function automatic desc_t mk(input int a, input int c, input int s, input int w);
        desc_t d;
        d.addr   = 6'(a);
        d.count  = 7'(c);
        d.stride = 4'(s);
        d.wen    = 1'(w);
        return d;
    endfunction

    // Reference: i-th address of a burst, wrapped modulo the address space.
    function automatic logic [5:0] model_addr(input desc_t d, input int i);
        int a;
        a = (int'(d.addr) + i * int'(d.stride)) % (1 << ADDR_W_DEF);
        return 6'(a);
    endfunction

    acc_t exp_q[$];
    int   bursts_expected;
    int   bursts_seen;

    task automatic model_push(input desc_t d);
        acc_t a;
        for (int i = 0; i < int'(d.count); i++) begin
            a.addr = model_addr(d, i);
            a.wen  = d.wen;
            a.last = (i == int'(d.count) - 1);
            exp_q.push_back(a);
        end
        bursts_expected++;
    endtask

    task automatic scoreboard_sample();
        acc_t got;
        if (burst_done) bursts_seen++;
        if (bus.mem_valid) begin
            check_output("rand_expected_access", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                got = '{addr: bus.mem_addr, wen: bus.mem_wen, last: bus.mem_last};
                check_output("rand_access", 32'(got), 32'(exp_q[0]));
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int   ea[5];
        int   el[5];
        int   eb[5];
        int   got_q[$];
        int   want[5];
        int   bd_bad;
        logic pushed_now;
        desc_t rd;

        vecs[0] = '{d: mk(0, 3, 1, 1),   exp: {6'd0,  6'd2,  6'd1,  6'd0}};
        vecs[1] = '{d: mk(7, 1, 5, 0),   exp: {6'd0,  6'd0,  6'd0,  6'd7}};
        vecs[2] = '{d: mk(3, 4, 0, 0),   exp: {6'd3,  6'd3,  6'd3,  6'd3}};
        vecs[3] = '{d: mk(60, 3, 15, 1), exp: {6'd0,  6'd26, 6'd11, 6'd60}};
        vecs[4] = '{d: mk(62, 3, 1, 0),  exp: {6'd0,  6'd0,  6'd63, 6'd62}};
        vecs[5] = '{d: mk(40, 4, 9, 1),  exp: {6'd3,  6'd58, 6'd49, 6'd40}};

        apply_stimulus(mk(0, 0, 0, 0), 1'b0);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_mem_valid", bus.mem_valid, 0);
        check_output("reset_mem_addr", bus.mem_addr, 0);
        check_output("reset_cmd_ready", bus.cmd_ready, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_burst_done", burst_done, 0);
`ifdef ADDR_GEN_WRAP_ERR_EN
        check_output("reset_wrap_err", wrap_err, 0);
`endif
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("cmd_ready_before_first_edge", bus.cmd_ready, 0);
        tick();
        check_output("cmd_ready_after_first_edge", bus.cmd_ready, 1);

        $display("[TB] directed table");
        bus.mem_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
`ifdef ADDR_GEN_WRAP_ERR_EN
            if (v == 3) check_output("wrap_err_before_wrap", wrap_err, 0);
`endif
            apply_stimulus(vecs[v].d, 1'b1);
            tick();
            bus.cmd_valid = 1'b0;
            check_output("vec_latency_gap", bus.mem_valid, 0);
            check_output("vec_busy_queued", busy, 1);
            tick();
            for (int i = 0; i < int'(vecs[v].d.count); i++) begin
                check_output("vec_valid", bus.mem_valid, 1);
                check_output("vec_addr", bus.mem_addr, 32'(vecs[v].exp[i]));
                check_output("vec_wen", bus.mem_wen, vecs[v].d.wen);
                check_output("vec_last", bus.mem_last, 32'(i == int'(vecs[v].d.count) - 1));
                check_output("vec_done_early", burst_done, 0);
                tick();
            end
            check_output("vec_end_valid", bus.mem_valid, 0);
            check_output("vec_burst_done", burst_done, 1);
            tick();
            check_output("vec_done_pulse_width", burst_done, 0);
            check_output("vec_idle_busy", busy, 0);
        end
`ifdef ADDR_GEN_WRAP_ERR_EN
        check_output("wrap_err_sticky", wrap_err, 1);
`endif

        $display("[TB] back-to-back bursts");
        ea = '{0, 1, 2, 10, 12};
        el = '{0, 0, 1, 0, 1};
        eb = '{0, 0, 0, 1, 0};
        apply_stimulus(mk(0, 3, 1, 0), 1'b1);
        tick();
        apply_stimulus(mk(10, 2, 2, 0), 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_output("b2b_valid", bus.mem_valid, 1);
            check_output("b2b_addr", bus.mem_addr, 32'(ea[i]));
            check_output("b2b_last", bus.mem_last, 32'(el[i]));
            check_output("b2b_burst_done", burst_done, 32'(eb[i]));
            tick();
        end
        check_output("b2b_end_valid", bus.mem_valid, 0);
        check_output("b2b_second_done", burst_done, 1);
        tick();

        $display("[TB] stall");
        apply_stimulus(mk(4, 4, 2, 1), 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check_output("stall_addr0", bus.mem_addr, 4);
        tick();
        check_output("stall_addr1", bus.mem_addr, 6);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("stall_hold_valid", bus.mem_valid, 1);
            check_output("stall_hold_addr", bus.mem_addr, 6);
            check_output("stall_hold_wen", bus.mem_wen, 1);
            check_output("stall_hold_last", bus.mem_last, 0);
        end
        bus.mem_ready = 1'b1;
        tick();
        check_output("stall_addr2", bus.mem_addr, 8);
        tick();
        check_output("stall_addr3", bus.mem_addr, 10);
        check_output("stall_last", bus.mem_last, 1);
        tick();
        check_output("stall_done", burst_done, 1);
        tick();

        $display("[TB] zero-count descriptor");
        apply_stimulus(mk(9, 0, 3, 0), 1'b1);
        tick();
        apply_stimulus(mk(5, 1, 1, 1), 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        check_output("zero_done", burst_done, 1);
        check_output("zero_no_access", bus.mem_valid, 0);
        tick();
        check_output("zero_next_valid", bus.mem_valid, 1);
        check_output("zero_next_addr", bus.mem_addr, 5);
        check_output("zero_next_last", bus.mem_last, 1);
        check_output("zero_next_wen", bus.mem_wen, 1);
        check_output("zero_done_cleared", burst_done, 0);
        tick();
        check_output("zero_next_done", burst_done, 1);
        tick();

        $display("[TB] fifo full while stalled");
        bus.mem_ready = 1'b0;
        apply_stimulus(mk(20, 2, 1, 0), 1'b1);
        tick();
        apply_stimulus(mk(30, 1, 0, 0), 1'b1);
        check_output("full_ready_c1", bus.cmd_ready, 1);
        tick();
        apply_stimulus(mk(40, 1, 0, 1), 1'b1);
        check_output("full_ready_c2", bus.cmd_ready, 1);
        tick();
        apply_stimulus(mk(50, 1, 0, 0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_output("full_ready_low", bus.cmd_ready, 0);
            check_output("full_stalled_addr", bus.mem_addr, 20);
            tick();
        end
        bus.mem_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_valid) got_q.push_back(int'(bus.mem_addr));
            pushed_now = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (pushed_now) bus.cmd_valid = 1'b0;
        end
        want = '{20, 21, 30, 40, 50};
        check_output("full_access_count", 32'(got_q.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check_output("full_access_addr", 32'(got_q[i]), 32'(want[i]));
        end

        $display("[TB] reset mid-burst");
        apply_stimulus(mk(0, 10, 1, 0), 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check_output("midrst_running", bus.mem_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_valid", bus.mem_valid, 0);
        check_output("midrst_addr", bus.mem_addr, 0);
        check_output("midrst_last", bus.mem_last, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_cmd_ready", bus.cmd_ready, 0);
`ifdef ADDR_GEN_WRAP_ERR_EN
        check_output("midrst_wrap_err", wrap_err, 0);
`endif
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bd_bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (burst_done || bus.mem_valid || busy) bd_bad++;
        end
        check_output("midrst_quiet_after", 32'(bd_bad), 0);

        $display("[TB] randomized run");
        exp_q.delete();
        bursts_expected = 0;
        bursts_seen     = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            scoreboard_sample();
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            if (bus.mem_valid && bus.mem_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            rd = mk(int'($urandom_range(0, 63)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
            apply_stimulus(rd, 1'($urandom_range(0, 1)));
            if (bus.cmd_valid && bus.cmd_ready) model_push(rd);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.mem_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            scoreboard_sample();
            if (bus.mem_valid && exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        check_output("rand_drained", 32'(exp_q.size()), 0);
        check_output("rand_burst_done_count", 32'(bursts_seen), 32'(bursts_expected));
        check_output("rand_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
